accum_drain: RTL

//  Read-side counterpart of the buffer load path: after a tile computes, drains rows of the

---
 rtl/accum_drain.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/accum_drain.sv
// Drains accumulator rows, requantizes each partial-sum lane to activation width
// and streams the rows out over a valid/ready port, one read in flight per row.
module accum_drain #(
  parameter int SYS_COLS   = 2,
  parameter int P_BITWIDTH = 24,
  parameter int A_BITWIDTH = 8,
  parameter int ACC_DEPTH  = 16,
  localparam int AW = $clog2(ACC_DEPTH),
  localparam int NW = $clog2(ACC_DEPTH + 1),
  localparam int SW = $clog2(P_BITWIDTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [AW-1:0]                  base_addr,
  input  logic [NW-1:0]                  num_rows,
  input  logic [SW-1:0]                  shift,
  output logic                           busy,
  output logic                           done,
  output logic                           acc_rd_en,
  output logic [AW-1:0]                  acc_rd_addr,
  input  logic [SYS_COLS*P_BITWIDTH-1:0] acc_rd_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SYS_COLS*A_BITWIDTH-1:0] out_data,
  output logic                           out_last
);

  // Output handshake: a row transfers on any rising edge where out_valid and
  // out_ready are both high; out_data/out_last stay frozen while out_valid waits.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_SEND  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [AW-1:0]                  base_q;
  logic [NW-1:0]                  n_q;
  logic [NW-1:0]                  row_q;
  logic [SW-1:0]                  shift_q;
  logic                           last_q;
  logic                           done_q;
  logic [SYS_COLS*A_BITWIDTH-1:0] data_q;

  logic [NW-1:0]                  n_clamped;
  logic                           is_last;
  logic [AW:0]                    addr_sum;
  logic [AW-1:0]                  rd_addr;
  logic [SYS_COLS*A_BITWIDTH-1:0] requant_row;

  function automatic logic [A_BITWIDTH-1:0] requant(
    input logic [P_BITWIDTH-1:0] x,
    input logic [SW-1:0]         sh
  );
    logic signed [P_BITWIDTH:0] ext;
    logic signed [P_BITWIDTH:0] rnd;
    logic signed [P_BITWIDTH:0] sum;
    logic signed [P_BITWIDTH:0] r;
    logic [P_BITWIDTH-A_BITWIDTH+1:0] top;
    ext = {x[P_BITWIDTH-1], x};
    rnd = '0;
    if (sh != '0) rnd = (P_BITWIDTH+1)'(1) << (sh - SW'(1));
    sum = ext + rnd;
    r   = sum >>> sh;
    // r fits in A bits only if every bit above the output sign bit matches it
    top = r[P_BITWIDTH:A_BITWIDTH-1];
    if ((&top) || !(|top)) requant = r[A_BITWIDTH-1:0];
    else if (r[P_BITWIDTH]) requant = {1'b1, {(A_BITWIDTH-1){1'b0}}};
    else                    requant = {1'b0, {(A_BITWIDTH-1){1'b1}}};
  endfunction

  always_comb begin
    n_clamped = (num_rows > NW'(ACC_DEPTH)) ? NW'(ACC_DEPTH) : num_rows;
    is_last   = (row_q == n_q - NW'(1));
    addr_sum  = {1'b0, base_q} + (AW+1)'(row_q);
    if (addr_sum >= (AW+1)'(ACC_DEPTH)) rd_addr = AW'(addr_sum - (AW+1)'(ACC_DEPTH));
    else                                rd_addr = addr_sum[AW-1:0];
  end

  always_comb begin
    requant_row = '0;
    for (int i = 0; i < SYS_COLS; i++) begin
      requant_row[i*A_BITWIDTH +: A_BITWIDTH] =
        requant(acc_rd_data[i*P_BITWIDTH +: P_BITWIDTH], shift_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start && (n_clamped != '0)) state_next = S_FETCH;
      S_FETCH: state_next = S_LOAD;
      S_LOAD:  state_next = S_SEND;
      S_SEND:  if (out_ready) state_next = is_last ? S_IDLE : S_FETCH;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q  <= '0;
      n_q     <= '0;
      row_q   <= '0;
      shift_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            n_q     <= n_clamped;
            shift_q <= shift;
            row_q   <= '0;
            if (n_clamped == '0) done_q <= 1'b1;
          end
        end
        S_LOAD: begin
          data_q <= requant_row;
          last_q <= is_last;
        end
        S_SEND: begin
          if (out_ready) begin
            row_q <= row_q + NW'(1);
            if (is_last) done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign done        = done_q;
  assign acc_rd_en   = (state == S_FETCH);
  assign acc_rd_addr = acc_rd_en ? rd_addr : '0;
  assign out_valid   = (state == S_SEND);
  assign out_last    = out_valid & last_q;
  assign out_data    = data_q;

endmodule
